// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and its consumer.
// Fetch-side and consumer-side signals share one bundle; the stage is the slave.
interface instr_decode_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [2:0]        opcode;
  logic [1:0]        op;
  logic [2:0]        rn;
  logic [2:0]        rd;
  logic [1:0]        sh_op;
  logic [2:0]        rm;
  logic [DATA_W-1:0] sximm5;
  logic [DATA_W-1:0] sximm8;
  logic              wr_en;
  logic [2:0]        wr_num;
  logic              illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, opcode, op, rn, rd,
    input  sh_op, rm, sximm5, sximm8, wr_en, wr_num, illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, opcode, op, rn, rd,
    output sh_op, rm, sximm5, sximm8, wr_en, wr_num, illegal
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Registered instruction-decode stage with a two-entry elastic buffer.
// M feeds the decoder, S absorbs one word of backpressure.
module instr_decode_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 9
) (
  input logic                 clk,
  input logic                 reset_n,
  instr_decode_stage_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [15:0]     instr;
    logic [PC_W-1:0] pc;
  } slot_t;

  slot_t m_q, s_q, m_d, s_d, in_slot;
  logic  rdy_q;
  logic  accept, emit;

  assign accept  = bus.in_valid & rdy_q;
  assign emit    = m_q.valid & bus.out_ready;
  assign in_slot = '{valid: 1'b1, instr: bus.in_instr, pc: bus.in_pc};

  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (bus.flush) begin
      m_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else if (!m_q.valid || emit) begin
      if (s_q.valid) begin
        m_d       = s_q;
        s_d.valid = 1'b0;
      end else if (accept) begin
        m_d = in_slot;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (accept) begin
      // accept implies S is empty, so S is never overwritten
      s_d = in_slot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q   <= '0;
      s_q   <= '0;
      rdy_q <= 1'b1;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      rdy_q <= !s_d.valid;
    end
  end

  logic [15:0] w;
  logic [2:0]  opc;
  logic [1:0]  opx;
  logic        we;
  logic [2:0]  wn;

  assign w   = m_q.instr;
  assign opc = w[15:13];
  assign opx = w[12:11];

  always_comb begin
    we = 1'b0;
    wn = w[7:5];
    unique case (1'b1)
      (opc == 3'b110 && opx == 2'b10): begin
        we = 1'b1;
        wn = w[10:8];
      end
      (opc == 3'b110 && opx == 2'b00),
      (opc == 3'b101 && opx != 2'b01),
      (opc == 3'b011):
        we = 1'b1;
      (opc == 3'b010 && opx == 2'b11): begin
        we = 1'b1;
        wn = 3'd7;
      end
      default: ;
    endcase
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = m_q.valid;
  assign bus.out_pc    = m_q.pc;
  assign bus.opcode    = opc;
  assign bus.op        = opx;
  assign bus.rn        = w[10:8];
  assign bus.rd        = w[7:5];
  assign bus.sh_op     = w[4:3];
  assign bus.rm        = w[2:0];
  assign bus.sximm5    = {{(DATA_W-5){w[4]}}, w[4:0]};
  assign bus.sximm8    = {{(DATA_W-8){w[7]}}, w[7:0]};
  assign bus.wr_en     = we;
  assign bus.wr_num    = wn;
  assign bus.illegal   = (opc == 3'b000);

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered, handshaked instruction-decode stage for the 16-bit RISC datapath, sitting between fetch and the register file/execute controller. It accepts one instruction word plus PC tag per valid/ready transfer, splits it into fields, sign-extends immediates to a parametrised datapath width, and derives register-file write control. A two-entry elastic buffer gives full throughput, with one-cycle latency and registered ready. It supports synchronous flush for taken branches.

## Interface
- DATA_W, 16: datapath width for sign-extended immediates; must be ≥ 8.
- PC_W, 9: width of the PC tag carried alongside each instruction.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  16  instruction word.
- in_pc  in  PC_W  PC tag of the instruction.
- flush  in  1  synchronous discard of all held instructions.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  consumer accepts.
- out_pc  out  PC_W  tag of the decoded instruction.
- opcode  out  3  in[15:13].
- op  out  2  in[12:11].
- rn  out  3  in[10:8].
- rd  out  3  in[7:5].
- sh_op  out  2  in[4:3].
- rm  out  3  in[2:0].
- sximm5  out  DATA_W  in[4:0] sign-extended.
- sximm8  out  DATA_W  in[7:0] sign-extended.
- wr_en  out  1  instruction writes a register.
- wr_num  out  3  destination register.
- illegal  out  1  opcode 3'b000.

## Operation
- Storage: main register M (drives outputs) and skid register S. Each holds instr, pc and a valid bit.
- Decode is combinational from M's stored word. All field outputs are pure functions of M and are held stable while out_valid=1 and out_ready=0.
- out_valid = M.valid. in_ready = !S.valid, and it is a flop output.
- Accept when in_valid & in_ready; emit when out_valid & out_ready.
- Accept with M empty, or with M emitting and S empty: word goes to M.
- Accept with M full and not emitting: word goes to S.
- Emit with S full: S moves to M; S is cleared.
- S is never written while full. Words leave in strict arrival order.
- wr_en/wr_num rules:
  - 110/op10 (MOV imm): wr_en=1, wr_num=rn.
  - 110/op00 (MOV reg): wr_en=1, wr_num=rd.
  - 101 with op≠01 (ADD/AND/MVN): wr_en=1, wr_num=rd.
  - 101/op01 (CMP): wr_en=0.
  - 011 (LDR): wr_en=1, wr_num=rd.
  - 010/op11 (BL): wr_en=1, wr_num=3'd7.
  - All other opcodes: wr_en=0, wr_num=rd.
- Sign extension: replicate bit 4 (sximm5) or bit 7 (sximm8) into all upper DATA_W bits.
- When out_valid=0, field outputs reflect the stale M contents; consumers must ignore them.

## Timing
- Reset (reset_n low, async): M.valid=0, S.valid=0, in_ready=1, out_valid=0. Stored instr=16'h0000 and pc=0, so opcode=0, illegal=1, wr_en=0 and all fields are 0.
- Latency: a word accepted at edge k is visible with out_valid=1 after edge k.
- Throughput: with out_ready held at 1, one word per cycle indefinitely.
- in_ready drops the cycle after S fills, and rises the cycle after S drains.
- flush at edge: M.valid=0, S.valid=0, in_ready=1.
  - A word offered on the same edge is dropped, not accepted.
  - An emit on the same edge still counts as consumed by the downstream.
- Reset asserted mid-transfer discards all contents immediately; no partial state survives.
- Simultaneous accept and emit with M full and S empty: new word lands directly in M. No bubble, and S stays empty.

## Test plan
- Reset check: assert reset_n=0 mid-stream → out_valid=0 and in_ready=1 at once, illegal=1, wr_en=0.
- MOV R2,#-91:
  - in_instr=16'hD2A5 with DATA_W=16 → one cycle later out_valid=1, opcode=6, op=2, rn=2, sximm8=16'hFFA5, wr_en=1, wr_num=2.
  - Repeat with DATA_W=32 → sximm8=32'hFFFFFFA5.
- ADD R3,R1,R0,LSL#1 followed by CMP:
  - in_instr=16'hA168 → rn=1, rd=3, sh_op=1, rm=0, wr_en=1, wr_num=3.
  - in_instr=16'hA968 → wr_en=0.
- Backpressure:
  - Stream PCs 1..4 with out_ready=0 → PC1 held in M, PC2 in S, in_ready=0 from the following cycle.
  - Then raise out_ready → outputs PC1,2,3,4 in order, no loss or duplication.
- Flush: M and S full, assert flush with in_valid=1 (PC9) → next cycle out_valid=0 and in_ready=1. PC9 never appears at the output.
- Full throughput: 20 back-to-back words with out_ready=1 → 20 outputs on 20 consecutive cycles, and in_ready stays 1 throughout.
